// File: rtl/joystick_conditioner.sv
// joystick_conditioner
// Conditions the five raw active-low DB9 joystick lines: 2-FF synchronisation
// into the system clock domain, per-line stable-time debounce, registered
// active-low line outputs, a Kempston-format byte and a one-cycle change strobe.
// Optional autofire modulation of the fire line is compiled in when the macro
// JOY_AUTOFIRE_EN is defined; otherwise the autofire input is ignored.
module joystick_conditioner #(
    parameter int unsigned DEBOUNCE      = 28000,
    parameter int unsigned AUTOFIRE_HALF = 1400000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       joyup,
    input  logic       joydown,
    input  logic       joyleft,
    input  logic       joyright,
    input  logic       joyfire,
    input  logic       autofire,
    output logic       joyup_o,
    output logic       joydown_o,
    output logic       joyleft_o,
    output logic       joyright_o,
    output logic       joyfire_o,
    output logic [7:0] kempston,
    output logic       change
);

    localparam int          NumLines = 5;
    localparam logic [15:0] DebLast  = 16'(DEBOUNCE - 1);

    // Line order matches the Kempston bit order: {fire, up, down, left, right}.
    logic [4:0] raw;
    assign raw = {joyfire, joyup, joydown, joyleft, joyright};

    logic [4:0]  sync1_q;
    logic [4:0]  sync2_q;
    logic [4:0]  state_q;
    logic [4:0]  state_d;
    logic [15:0] cnt_q [NumLines];
    logic [15:0] cnt_d [NumLines];
    logic [4:0]  out_q;
    logic [4:0]  out_d;
    logic        change_q;
    logic        change_d;
    logic        fire_eff_d;

    // Two-flop synchroniser for every raw line; reset to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-line debounce: the state follows the synchronised line only after
    // it has differed for DEBOUNCE consecutive cycles.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < NumLines; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DebLast) begin
                state_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Debounce state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '1;
            for (int i = 0; i < NumLines; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NumLines; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef JOY_AUTOFIRE_EN
    localparam logic [23:0] AfLast = 24'(AUTOFIRE_HALF - 1);

    logic [23:0] af_cnt_q;
    logic [23:0] af_cnt_d;
    logic        af_phase_q;
    logic        af_phase_d;

    // Autofire square wave: runs only while requested and fire is held, so
    // the first press phase is always the active one.
    always_comb begin
        af_cnt_d   = af_cnt_q;
        af_phase_d = af_phase_q;
        if (!autofire || state_q[4]) begin
            af_cnt_d   = '0;
            af_phase_d = 1'b0;
        end else if (af_cnt_q == AfLast) begin
            af_cnt_d   = '0;
            af_phase_d = ~af_phase_q;
        end else begin
            af_cnt_d = af_cnt_q + 24'd1;
        end
    end

    // Autofire counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
        end else begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
        end
    end

    // Active-low: the line reads released during the off phase.
    assign fire_eff_d = state_d[4] | (autofire & af_phase_d);
`else
    logic unused_autofire;
    assign unused_autofire = autofire;
    assign fire_eff_d      = state_d[4];
`endif

    // Outputs are taken from next-state so they move on the same edge as the
    // debounced state; change flags any bit moving on that edge.
    assign out_d    = {fire_eff_d, state_d[3:0]};
    assign change_d = (out_d != out_q);

    // Registered outputs and change strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '1;
            change_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            change_q <= change_d;
        end
    end

    assign joyright_o = out_q[0];
    assign joyleft_o  = out_q[1];
    assign joydown_o  = out_q[2];
    assign joyup_o    = out_q[3];
    assign joyfire_o  = out_q[4];
    assign kempston   = {3'b000, ~out_q};
    assign change     = change_q;

endmodule
